// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous VRAM32 port between the BGW renderer (A),
// the sprite renderer (B) and the CPU. Renderers are served round-robin every
// cycle; the CPU takes cycles left free by the renderers. Read data is steered
// back to its issuer by a {valid, owner} tag pipeline that matches the RAM latency.
//
// Build option: define VRAM_ARB_CPU_ACTIVE_EN to let the CPU use free cycles in
// the active display area too. Without it, the CPU is served only while blank=1.
//
// CPU FSM
//   state | meaning
//   IDLE  | no CPU access in flight, a new request may be granted
//   BUSY  | CPU access granted, waiting for the write ack or read data return
module vram_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              blank,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_q,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] OWN_A   = 2'd0;
    localparam logic [1:0] OWN_B   = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;

    // Tag stage k describes the access whose address was at the RAM k cycles ago;
    // the last stage lines up with ram_q.
    logic [RAM_LAT:0][2:0] tag_q, tag_d;
    logic [0:0]            state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;     // 0 = A next on contention, 1 = B
    logic                  cpu_wr_ack_q, cpu_wr_ack_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]     ram_d_q, ram_d_d;
    logic                  ram_we_q, ram_we_d;

    logic grant_a, grant_b, grant_cpu, cpu_slot_ok;
    logic [2:0] ret_tag;
    logic cpu_rd_ack;

`ifdef VRAM_ARB_CPU_ACTIVE_EN
    logic blank_unused;
    assign blank_unused = blank;
    assign cpu_slot_ok  = 1'b1;
`else
    assign cpu_slot_ok  = blank;
`endif

    // Grant decision: renderers first (round-robin on contention), CPU on a free slot.
    always_comb begin
        grant_a   = a_req & (~b_req | ~rr_ptr_q);
        grant_b   = b_req & ~grant_a;
        grant_cpu = ~(a_req | b_req) & cpu_req & (state_q == ST_IDLE) & cpu_slot_ok;
    end

    // Next-state values for the RAM port, pointer and CPU write ack.
    always_comb begin
        ram_addr_d   = ram_addr_q;
        ram_d_d      = ram_d_q;
        ram_we_d     = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        cpu_wr_ack_d = 1'b0;
        if (grant_a) begin
            ram_addr_d = a_addr;
            rr_ptr_d   = 1'b1;
        end else if (grant_b) begin
            ram_addr_d = b_addr;
            rr_ptr_d   = 1'b0;
        end else if (grant_cpu) begin
            ram_addr_d   = cpu_addr;
            ram_d_d      = cpu_d;
            ram_we_d     = cpu_we;
            cpu_wr_ack_d = cpu_we;
        end
    end

    // Tag pipeline: only reads enter it; writes are acked directly one cycle later.
    always_comb begin
        tag_d = tag_q;
        if (grant_a)
            tag_d[0] = {1'b1, OWN_A};
        else if (grant_b)
            tag_d[0] = {1'b1, OWN_B};
        else if (grant_cpu && !cpu_we)
            tag_d[0] = {1'b1, OWN_CPU};
        else
            tag_d[0] = 3'b000;
        for (int k = 1; k <= RAM_LAT; k++)
            tag_d[k] = tag_q[k-1];
    end

    // Return side: decode the tag that matches the current ram_q.
    always_comb begin
        ret_tag    = tag_q[RAM_LAT];
        a_valid    = ret_tag[2] && (ret_tag[1:0] == OWN_A);
        b_valid    = ret_tag[2] && (ret_tag[1:0] == OWN_B);
        cpu_rd_ack = ret_tag[2] && (ret_tag[1:0] == OWN_CPU);
        cpu_ack    = cpu_wr_ack_q | cpu_rd_ack;
        a_q        = a_valid    ? ram_q : '0;
        b_q        = b_valid    ? ram_q : '0;
        cpu_q      = cpu_rd_ack ? ram_q : '0;
    end

    // CPU FSM: busy from grant until its ack, so a request held into the ack cycle is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_cpu) state_d = ST_BUSY;
            ST_BUSY: if (cpu_ack)   state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight tag.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            tag_q        <= '0;
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            cpu_wr_ack_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_d_q      <= '0;
            ram_we_q     <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cpu_wr_ack_q <= cpu_wr_ack_d;
            ram_addr_q   <= ram_addr_d;
            ram_d_q      <= ram_d_d;
            ram_we_q     <= ram_we_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_d    = ram_d_q;
    assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors for vram_arbiter with a one-cycle-latency
// behavioural VRAM attached to the RAM port.
module tb_vram_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              vga_clk = 1'b0;
    logic              reset, blank;
    logic              a_req, b_req, cpu_req, cpu_we;
    logic [ADDR_W-1:0] a_addr, b_addr, cpu_addr;
    logic [DATA_W-1:0] cpu_d;
    logic              a_valid, b_valid, cpu_ack, ram_we;
    logic [DATA_W-1:0] a_q, b_q, cpu_q, ram_d, ram_q;
    logic [ADDR_W-1:0] ram_addr;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(1)) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .blank   (blank),
        .a_req   (a_req),
        .a_addr  (a_addr),
        .a_valid (a_valid),
        .a_q     (a_q),
        .b_req   (b_req),
        .b_addr  (b_addr),
        .b_valid (b_valid),
        .b_q     (b_q),
        .cpu_req (cpu_req),
        .cpu_we  (cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_d   (cpu_d),
        .cpu_q   (cpu_q),
        .cpu_ack (cpu_ack),
        .ram_addr(ram_addr),
        .ram_d   (ram_d),
        .ram_we  (ram_we),
        .ram_q   (ram_q)
    );

    // Synchronous VRAM, read-before-write, one cycle read latency.
    always @(posedge vga_clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle_inputs();
        blank = 1'b0; a_req = 1'b0; b_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        a_addr = '0; b_addr = '0; cpu_addr = '0; cpu_d = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".a_valid"},  {31'd0, a_valid}, 32'd0);
        check({tag, ".b_valid"},  {31'd0, b_valid}, 32'd0);
        check({tag, ".cpu_ack"},  {31'd0, cpu_ack}, 32'd0);
        check({tag, ".ram_we"},   {31'd0, ram_we},  32'd0);
        check({tag, ".ram_addr"}, {18'd0, ram_addr}, 32'd0);
        check({tag, ".ram_d"},    ram_d, 32'd0);
        check({tag, ".cpu_q"},    cpu_q, 32'd0);
        check({tag, ".a_q"},      a_q,   32'd0);
        check({tag, ".b_q"},      b_q,   32'd0);
    endtask

    logic [ADDR_W-1:0] rr_addr [4];
    int acks;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[14'h0010] = 32'hDEADBEEF;
        mem[14'h0100] = 32'hAAAA0100;
        mem[14'h0200] = 32'hBBBB0200;
        mem[14'h0020] = 32'h55AA55AA;
        mem[14'h0030] = 32'hC0FFEE30;
        rr_addr[0] = 14'h100; rr_addr[1] = 14'h200; rr_addr[2] = 14'h100; rr_addr[3] = 14'h200;

        do_reset();
        check_all_zero("reset");

        // Single A read
        a_req = 1'b1; a_addr = 14'h0010;
        tick();
        check("t1.ram_addr", {18'd0, ram_addr}, 32'h0010);
        check("t1.ram_we",   {31'd0, ram_we}, 32'd0);
        check("t1.a_valid_early", {31'd0, a_valid}, 32'd0);
        a_req = 1'b0;
        tick();
        check("t1.a_valid", {31'd0, a_valid}, 32'd1);
        check("t1.a_q",     a_q, 32'hDEADBEEF);
        check("t1.b_valid", {31'd0, b_valid}, 32'd0);
        tick();
        check("t1.a_valid_once", {31'd0, a_valid}, 32'd0);

        // Round-robin A/B contention
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_addr = 14'h100; b_addr = 14'h200;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) begin a_req = 1'b0; b_req = 1'b0; end
            if (i < 4) check($sformatf("rr.ram_addr%0d", i), {18'd0, ram_addr}, {18'd0, rr_addr[i]});
            if (i >= 1 && i <= 4) begin
                check($sformatf("rr.a_valid%0d", i), {31'd0, a_valid}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("rr.b_valid%0d", i), {31'd0, b_valid}, ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("rr.q%0d", i), a_q | b_q,
                      ((i - 1) % 2 == 0) ? 32'hAAAA0100 : 32'hBBBB0200);
            end
            if (i == 5) check("rr.quiet", {30'd0, a_valid, b_valid}, 32'd0);
        end

        // CPU write then read during blank
        do_reset();
        blank = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_d = 32'h12345678;
        tick();
        check("cw.ack",      {31'd0, cpu_ack}, 32'd1);
        check("cw.ram_we",   {31'd0, ram_we},  32'd1);
        check("cw.ram_addr", {18'd0, ram_addr}, 32'h3FFF);
        check("cw.ram_d",    ram_d, 32'h12345678);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("cw.ack_once", {31'd0, cpu_ack}, 32'd0);
        check("cw.we_off",   {31'd0, ram_we},  32'd0);
        cpu_req = 1'b1;
        tick();
        check("cr.ack_early", {31'd0, cpu_ack}, 32'd0);
        check("cr.ram_we",    {31'd0, ram_we},  32'd0);
        tick();
        check("cr.ack",   {31'd0, cpu_ack}, 32'd1);
        check("cr.cpu_q", cpu_q, 32'h12345678);
        cpu_req = 1'b0;
        tick();
        check("cr.ack_once", {31'd0, cpu_ack}, 32'd0);

        // CPU read during active area
        do_reset();
        blank = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0030;
`ifdef VRAM_ARB_CPU_ACTIVE_EN
        tick();
        check("act.ack_early", {31'd0, cpu_ack}, 32'd0);
        tick();
        check("act.ack",   {31'd0, cpu_ack}, 32'd1);
        check("act.cpu_q", cpu_q, 32'hC0FFEE30);
        cpu_req = 1'b0;
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("act.no_ack%0d", i), {31'd0, cpu_ack}, 32'd0);
        end
        blank = 1'b1;
        tick();
        check("act.ack_early", {31'd0, cpu_ack}, 32'd0);
        tick();
        check("act.ack",   {31'd0, cpu_ack}, 32'd1);
        check("act.cpu_q", cpu_q, 32'hC0FFEE30);
        cpu_req = 1'b0;
`endif
        tick();
        check("act.ack_once", {31'd0, cpu_ack}, 32'd0);

        // Render beats CPU; CPU granted on first free cycle
        do_reset();
        blank = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_addr = 14'h100; b_addr = 14'h200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("pri.ram_addr%0d", i), {18'd0, ram_addr}, {18'd0, rr_addr[i]});
            if (cpu_ack) acks++;
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
        check("pri.cpu_grant_addr", {18'd0, ram_addr}, 32'h0020);
        if (cpu_ack) acks++;
        tick();
        check("pri.ack",   {31'd0, cpu_ack}, 32'd1);
        check("pri.cpu_q", cpu_q, 32'h55AA55AA);
        if (cpu_ack) acks++;
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack) acks++;
        end
        check("pri.ack_count", acks, 32'd1);

        // Reset right after an A grant drops the in-flight tag
        do_reset();
        a_req = 1'b1; a_addr = 14'h0010;
        tick();
        check("rst.ram_addr", {18'd0, ram_addr}, 32'h0010);
        reset = 1'b1; a_req = 1'b0;
        tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();
        check("rst.no_late_valid", {31'd0, a_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
